bp_me_cce_to_cache_banked: RTL and testbench

- Converts block-streamed BedRock-style memory commands into bsg_cache packets for N address-interleaved L2 banks, and reassembles bank read data into an in-order response stream.
- Sits between the CCE/IO memory network and a bank array of bsg_cache instances.
- Successor to the single-bank converter. Adds a bank-count parameter, a configurable stream width, critical-word-first wrap addressing, and in-order response reassembly across banks.

---
 rtl/bp_me_cce_to_cache_banked.sv | 243 ++++++++++++++++++++++++
 tb/tb_bp_me_cce_to_cache_banked.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_cce_to_cache_banked.sv
// Converts streamed memory commands into bsg_cache packets for address-interleaved banks,
// and returns bank read data to the requester in command order.
`timescale 1ns/1ps
module bp_me_cce_to_cache_banked #(
  parameter int num_banks_p    = 2,
  parameter int paddr_width_p  = 40,
  parameter int data_width_p   = 64,
  parameter int block_width_p  = 512,
  parameter int sets_p         = 64,
  parameter int assoc_p        = 8,
  parameter int header_width_p = 64,
  parameter int order_els_p    = 4,
  parameter logic [paddr_width_p-1:0] dram_base_p = 'h8000_0000,
  parameter logic [19:0] tagfl_addr_p = 20'h0_2000,
  localparam int bank_w_lp     = $clog2(num_banks_p),
  localparam int caddr_w_lp    = paddr_width_p - bank_w_lp,
  localparam int pkt_width_lp  = 6 + caddr_w_lp + data_width_p + data_width_p/8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [header_width_p-1:0]              cmd_header_i,
  input  logic [paddr_width_p-1:0]               cmd_addr_i,
  input  logic [2:0]                             cmd_size_i,
  input  logic                                   cmd_wr_i,
  input  logic [data_width_p-1:0]                cmd_data_i,
  input  logic                                   cmd_v_i,
  output logic                                   cmd_ready_o,
  output logic [header_width_p-1:0]              resp_header_o,
  output logic [data_width_p-1:0]                resp_data_o,
  output logic                                   resp_v_o,
  output logic                                   resp_last_o,
  input  logic                                   resp_yumi_i,
  output logic                                   init_done_o,
  output logic [num_banks_p*pkt_width_lp-1:0]    cache_pkt_o,
  output logic [num_banks_p-1:0]                 cache_pkt_v_o,
  input  logic [num_banks_p-1:0]                 cache_pkt_ready_i,
  input  logic [num_banks_p*data_width_p-1:0]    cache_data_i,
  input  logic [num_banks_p-1:0]                 cache_v_i,
  output logic [num_banks_p-1:0]                 cache_yumi_o
);

  localparam int blk_bytes  = block_width_p / 8;
  localparam int off_w      = $clog2(blk_bytes);
  localparam int word_bytes = data_width_p / 8;
  localparam int lg_word    = $clog2(word_bytes);
  localparam int sel_w      = (bank_w_lp == 0) ? 1 : bank_w_lp;
  localparam int tags       = sets_p * assoc_p;
  localparam int tag_w      = $clog2(tags + 1);
  localparam int ptr_w      = (order_els_p > 1) ? $clog2(order_els_p) : 1;
  localparam int qcnt_w     = $clog2(order_els_p + 1);
  localparam int cnt_w      = 8;

  localparam logic [5:0] LB = 6'h00, LH = 6'h01, LW = 6'h02, LD = 6'h03, LM = 6'h07;
  localparam logic [5:0] SB = 6'h08, SH = 6'h09, SW = 6'h0A, SD = 6'h0B, SM = 6'h0F;
  localparam logic [5:0] TAGST = 6'h10, TAGFL = 6'h11;

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY, S_STREAM} state_e;

  function automatic logic [cnt_w-1:0] beats_of(input logic [2:0] size);
    if (int'(size) > lg_word) return cnt_w'(1) << (int'(size) - lg_word);
    return cnt_w'(1);
  endfunction

  function automatic logic [5:0] op_of(input logic [2:0] size, input logic wr, input logic fl);
    if (fl) return TAGFL;
    case (size)
      3'd0:    return wr ? SB : LB;
      3'd1:    return wr ? SH : LH;
      3'd2:    return wr ? SW : LW;
      3'd3:    return wr ? SD : LD;
      default: return wr ? SM : LM;
    endcase
  endfunction

  // Squeeze the bank-select bits out of the address; the block offset stays in place.
  function automatic logic [caddr_w_lp-1:0] strip_bank(input logic [paddr_width_p-1:0] a);
    logic [paddr_width_p-1:0] hi, lo;
    hi = (a >> (off_w + bank_w_lp)) << off_w;
    lo = a & paddr_width_p'(blk_bytes - 1);
    return caddr_w_lp'(hi | lo);
  endfunction

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (int'(p) == order_els_p - 1) ? '0 : p + 1'b1;
  endfunction

  state_e                  state;
  logic [tag_w-1:0]        clr_idx;
  logic [tag_w-1:0]        clr_cnt [num_banks_p];
  logic                    init_done;
  logic [sel_w-1:0]        str_bank;
  logic [5:0]              str_op;
  logic [caddr_w_lp-1:0]   str_base;
  logic [off_w-1:0]        str_off;
  logic [cnt_w-1:0]        str_k, str_beats;

  logic [header_width_p-1:0] q_hdr   [order_els_p];
  logic [sel_w-1:0]          q_bank  [order_els_p];
  logic [cnt_w-1:0]          q_beats [order_els_p];
  logic                      q_wr    [order_els_p];
  logic [ptr_w-1:0]          wr_ptr, rd_ptr;
  logic [qcnt_w-1:0]         q_cnt;
  logic [cnt_w-1:0]          resp_cnt;

  logic                    is_csr, tagfl, full, empty, push, pop, drain_done, clr_issue;
  logic [sel_w-1:0]        cmd_bank, head_bank;
  logic [cnt_w-1:0]        cmd_beats;
  logic [5:0]              cmd_op, pkt_op;
  logic [caddr_w_lp-1:0]   pkt_addr;
  logic [data_width_p-1:0] pkt_data;
  logic [word_bytes-1:0]   pkt_mask;
  logic [off_w-1:0]        wrap;
  logic                    resp_active;

  always_comb begin
    is_csr    = cmd_addr_i < dram_base_p;
    tagfl     = is_csr && (cmd_addr_i[19:0] == tagfl_addr_p);
    cmd_bank  = '0;
    if (bank_w_lp != 0)
      cmd_bank = tagfl ? cmd_data_i[0 +: sel_w] : cmd_addr_i[off_w +: sel_w];
    cmd_beats = beats_of(cmd_size_i);
    cmd_op    = op_of(cmd_size_i, cmd_wr_i, tagfl);
    full      = q_cnt == qcnt_w'(order_els_p);
    empty     = q_cnt == '0;
    wrap      = str_off + off_w'(int'(str_k) * word_bytes);

    drain_done = 1'b1;
    for (int b = 0; b < num_banks_p; b++)
      if (clr_cnt[b] != tag_w'(tags)) drain_done = 1'b0;

    pkt_op        = cmd_op;
    pkt_addr      = strip_bank(cmd_addr_i);
    pkt_data      = cmd_data_i;
    pkt_mask      = '1;
    cache_pkt_v_o = '0;
    cmd_ready_o   = 1'b0;
    clr_issue     = 1'b0;
    case (state)
      S_CLEAR: begin
        pkt_op    = TAGST;
        pkt_addr  = caddr_w_lp'(clr_idx) << off_w;
        pkt_data  = '0;
        clr_issue = (&cache_pkt_ready_i) && (clr_idx < tag_w'(tags));
        cache_pkt_v_o = {num_banks_p{clr_issue}};
      end
      S_READY: begin
        if (tagfl) pkt_addr = caddr_w_lp'(cmd_data_i >> bank_w_lp) << off_w;
        cmd_ready_o = cache_pkt_ready_i[cmd_bank] && !full;
        cache_pkt_v_o[cmd_bank] = cmd_v_i && cmd_ready_o;
      end
      S_STREAM: begin
        pkt_op      = str_op;
        pkt_addr    = str_base | caddr_w_lp'(wrap);
        cmd_ready_o = cache_pkt_ready_i[str_bank];
        cache_pkt_v_o[str_bank] = cmd_v_i && cmd_ready_o;
      end
      default: ;
    endcase

    head_bank     = q_bank[rd_ptr];
    resp_active   = (state == S_READY || state == S_STREAM) && !empty;
    resp_v_o      = resp_active && cache_v_i[head_bank];
    resp_header_o = q_hdr[rd_ptr];
    resp_data_o   = q_wr[rd_ptr] ? '0 : cache_data_i[int'(head_bank)*data_width_p +: data_width_p];
    resp_last_o   = resp_cnt == (q_beats[rd_ptr] - 1'b1);
    cache_yumi_o  = '0;
    if (state == S_CLEAR) cache_yumi_o = cache_v_i;
    else if (resp_v_o && resp_yumi_i) cache_yumi_o[head_bank] = 1'b1;

    push = (state == S_READY) && cmd_v_i && cmd_ready_o;
    pop  = resp_v_o && resp_yumi_i && resp_last_o;
  end

  assign cache_pkt_o = {num_banks_p{pkt_op, pkt_addr, pkt_data, pkt_mask}};
  assign init_done_o = init_done;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= S_RESET;
      init_done <= 1'b0;
      clr_idx   <= '0;
      for (int b = 0; b < num_banks_p; b++) clr_cnt[b] <= '0;
      str_bank  <= '0;
      str_op    <= '0;
      str_base  <= '0;
      str_off   <= '0;
      str_k     <= '0;
      str_beats <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_cnt     <= '0;
      resp_cnt  <= '0;
    end else begin
      case (state)
        S_RESET: state <= S_CLEAR;
        S_CLEAR: begin
          if (clr_issue) clr_idx <= clr_idx + 1'b1;
          for (int b = 0; b < num_banks_p; b++)
            if (cache_v_i[b] && clr_cnt[b] != tag_w'(tags)) clr_cnt[b] <= clr_cnt[b] + 1'b1;
          if (drain_done) begin
            state     <= S_READY;
            init_done <= 1'b1;
          end
        end
        S_READY: begin
          if (push && cmd_beats != cnt_w'(1)) begin
            state     <= S_STREAM;
            str_bank  <= cmd_bank;
            str_op    <= cmd_op;
            str_base  <= strip_bank(cmd_addr_i) & ~caddr_w_lp'(blk_bytes - 1);
            str_off   <= cmd_addr_i[off_w-1:0];
            str_k     <= cnt_w'(1);
            str_beats <= cmd_beats;
          end
        end
        S_STREAM: begin
          if (cmd_v_i && cmd_ready_o) begin
            str_k <= str_k + 1'b1;
            if (str_k == str_beats - 1'b1) state <= S_READY;
          end
        end
        default: state <= S_RESET;
      endcase

      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      q_cnt <= q_cnt + 1'b1;
      else if (!push && pop) q_cnt <= q_cnt - 1'b1;
      if (resp_v_o && resp_yumi_i) resp_cnt <= resp_last_o ? '0 : resp_cnt + 1'b1;
    end
  end

  // Ordering payload is only meaningful behind the pointers, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_hdr[wr_ptr]   <= cmd_header_i;
      q_bank[wr_ptr]  <= cmd_bank;
      q_beats[wr_ptr] <= cmd_beats;
      q_wr[wr_ptr]    <= cmd_wr_i;
    end
  end

endmodule

// File: tb/tb_bp_me_cce_to_cache_banked.sv
// Directed bench for bp_me_cce_to_cache_banked with a two-bank return model.
`timescale 1ns/1ps
module tb_bp_me_cce_to_cache_banked;
  localparam int PW = 117;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [63:0]  cmd_header_i;
  logic [39:0]  cmd_addr_i;
  logic [2:0]   cmd_size_i;
  logic         cmd_wr_i;
  logic [63:0]  cmd_data_i;
  logic         cmd_v_i;
  logic         cmd_ready_o;
  logic [63:0]  resp_header_o;
  logic [63:0]  resp_data_o;
  logic         resp_v_o;
  logic         resp_last_o;
  logic         resp_yumi_i;
  logic         init_done_o;
  logic [2*PW-1:0] cache_pkt_o;
  logic [1:0]   cache_pkt_v_o;
  logic [1:0]   cache_pkt_ready_i;
  logic [127:0] cache_data_i;
  logic [1:0]   cache_v_i;
  logic [1:0]   cache_yumi_o;

  always #5 clk = ~clk;

  bp_me_cce_to_cache_banked dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_header_i(cmd_header_i), .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i),
    .cmd_wr_i(cmd_wr_i), .cmd_data_i(cmd_data_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .resp_header_o(resp_header_o), .resp_data_o(resp_data_o), .resp_v_o(resp_v_o),
    .resp_last_o(resp_last_o), .resp_yumi_i(resp_yumi_i), .init_done_o(init_done_o),
    .cache_pkt_o(cache_pkt_o), .cache_pkt_v_o(cache_pkt_v_o), .cache_pkt_ready_i(cache_pkt_ready_i),
    .cache_data_i(cache_data_i), .cache_v_i(cache_v_i), .cache_yumi_o(cache_yumi_o)
  );

  // Bank model: every accepted packet returns one word = address ^ A5A5_0000_0000_0000.
  logic [63:0] rq [2][1024];
  int          wp [2];
  int          rp [2];
  logic [5:0]  lop   [2][2048];
  logic [38:0] laddr [2][2048];
  logic [63:0] ldata [2][2048];
  int          npkt [2] = '{0, 0};
  logic [1:0]  en;

  assign cache_v_i[0] = en[0] && (wp[0] != rp[0]);
  assign cache_v_i[1] = en[1] && (wp[1] != rp[1]);
  assign cache_data_i[63:0]   = rq[0][rp[0][9:0]];
  assign cache_data_i[127:64] = rq[1][rp[1][9:0]];

  always @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int b = 0; b < 2; b++) begin
        wp[b] <= 0;
        rp[b] <= 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (cache_pkt_v_o[b] && cache_pkt_ready_i[b]) begin
          rq[b][wp[b][9:0]]      <= {25'b0, cache_pkt_o[b*PW+72 +: 39]} ^ 64'hA5A5_0000_0000_0000;
          wp[b]                  <= wp[b] + 1;
          lop[b][npkt[b][10:0]]   <= cache_pkt_o[b*PW+111 +: 6];
          laddr[b][npkt[b][10:0]] <= cache_pkt_o[b*PW+72 +: 39];
          ldata[b][npkt[b][10:0]] <= cache_pkt_o[b*PW+8 +: 64];
          npkt[b]                <= npkt[b] + 1;
        end
        if (cache_yumi_o[b]) rp[b] <= rp[b] + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] hdr, input logic [39:0] addr, input logic [2:0] size,
                           input logic wr, input logic [63:0] data);
    int t;
    cmd_header_i = hdr; cmd_addr_i = addr; cmd_size_i = size; cmd_wr_i = wr; cmd_data_i = data;
    cmd_v_i = 1'b1;
    #1;
    t = 0;
    while (!cmd_ready_o && t < 50) begin
      step();
      t++;
    end
    if (!cmd_ready_o) chk("cmd_accept_timeout", 64'(cmd_ready_o), 64'd1);
    @(posedge clk);
    #1;
    cmd_v_i = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int t;
    t = 0;
    while (!resp_v_o && t < 50) begin
      step();
      t++;
    end
    chk(tag, 64'(resp_v_o), 64'd1);
  endtask

  task automatic wait_init();
    int t, early;
    t = 0;
    early = 0;
    while (!init_done_o && t < 3000) begin
      if (cmd_ready_o) early++;
      step();
      t++;
    end
    chk("init_done", 64'(init_done_o), 64'd1);
    chk("ready_before_init", 64'(early), 64'd0);
  endtask

  task automatic pop_one();
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, errs, nb, last_at, derr;
    logic [63:0] exp_hdr  [4];
    logic [63:0] exp_data [4];

    reset_i = 1'b0; cmd_v_i = 1'b0; cmd_header_i = '0; cmd_addr_i = '0; cmd_size_i = '0;
    cmd_wr_i = 1'b0; cmd_data_i = '0; resp_yumi_i = 1'b0; cache_pkt_ready_i = 2'b11; en = 2'b11;
    repeat (3) step();
    cmd_v_i = 1'b1;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_resp_v", 64'(resp_v_o), 64'd0);
    chk("rst_init_done", 64'(init_done_o), 64'd0);
    chk("rst_pkt_v", 64'(cache_pkt_v_o), 64'd0);
    chk("rst_yumi", 64'(cache_yumi_o), 64'd0);
    cmd_v_i = 1'b0;

    // Tag clear: 512 TAGST per bank, index << 6.
    reset_i = 1'b1;
    wait_init();
    chk("tagst_count_b0", 64'(npkt[0]), 64'd512);
    chk("tagst_count_b1", 64'(npkt[1]), 64'd512);
    errs = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 512; i++)
        if (lop[b][i[10:0]] != 6'h10 || laddr[b][i[10:0]] != (39'(i) << 6) || ldata[b][i[10:0]] != 64'd0)
          errs++;
    chk("tagst_content", 64'(errs), 64'd0);

    // 8-byte read to bank 1.
    b1 = npkt[1];
    send_beat(64'h1111, 40'h00_8000_0040, 3'd3, 1'b0, 64'd0);
    chk("ld_pkt_count", 64'(npkt[1] - b1), 64'd1);
    chk("ld_opcode", 64'(lop[1][b1[10:0]]), 64'h03);
    chk("ld_addr", 64'(laddr[1][b1[10:0]]), 64'h4000_0000);
    wait_resp("ld_resp_v");
    chk("ld_data", resp_data_o, 64'hA5A5_0000_4000_0000);
    chk("ld_last", 64'(resp_last_o), 64'd1);
    chk("ld_header", resp_header_o, 64'h1111);
    pop_one();
    chk("ld_resp_gone", 64'(resp_v_o), 64'd0);

    // 64-byte write at 0x10: eight SM beats with wraparound.
    b0 = npkt[0];
    for (int k = 0; k < 8; k++) send_beat(64'h2222, 40'h00_8000_0010, 3'd6, 1'b1, 64'h100 + 64'(k));
    chk("sm_pkt_count", 64'(npkt[0] - b0), 64'd8);
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      if (lop[0][11'(b0 + k)] != 6'h0F) errs++;
      if (laddr[0][11'(b0 + k)] != (39'h4000_0000 | 39'((16 + 8 * k) % 64))) errs++;
      if (ldata[0][11'(b0 + k)] != 64'h100 + 64'(k)) errs++;
    end
    chk("sm_beats_content", 64'(errs), 64'd0);
    nb = 0; last_at = 0; derr = 0;
    resp_yumi_i = 1'b1;
    for (int t = 0; t < 60 && last_at == 0; t++) begin
      if (resp_v_o) begin
        nb++;
        if (resp_data_o != 64'd0 || resp_header_o != 64'h2222) derr++;
        if (resp_last_o) last_at = nb;
      end
      step();
    end
    resp_yumi_i = 1'b0;
    chk("sm_resp_beats", 64'(nb), 64'd8);
    chk("sm_resp_last_pos", 64'(last_at), 64'd8);
    chk("sm_resp_data", 64'(derr), 64'd0);

    // Bank 1 returns first but must wait for bank 0.
    en = 2'b10;
    send_beat(64'hA0, 40'h00_8000_0100, 3'd3, 1'b0, 64'd0);
    send_beat(64'hB1, 40'h00_8000_01C8, 3'd3, 1'b0, 64'd0);
    step();
    resp_yumi_i = 1'b1;
    #1;
    chk("order_hold_resp_v", 64'(resp_v_o), 64'd0);
    chk("order_hold_yumi", 64'(cache_yumi_o), 64'd0);
    step();
    chk("order_hold_yumi2", 64'(cache_yumi_o), 64'd0);
    en = 2'b11;
    #1;
    chk("order_first_hdr", resp_header_o, 64'hA0);
    chk("order_first_data", resp_data_o, 64'hA5A5_0000_4000_0080);
    chk("order_first_yumi", 64'(cache_yumi_o), 64'b01);
    step();
    chk("order_second_hdr", resp_header_o, 64'hB1);
    chk("order_second_data", resp_data_o, 64'hA5A5_0000_4000_00C8);
    chk("order_second_yumi", 64'(cache_yumi_o), 64'b10);
    step();
    resp_yumi_i = 1'b0;
    #1;
    chk("order_drained", 64'(resp_v_o), 64'd0);

    // Ordering FIFO full.
    for (int k = 0; k < 4; k++) send_beat(64'hC0 + 64'(k), 40'h00_8000_0000 + 40'(k * 128), 3'd3, 1'b0, 64'd0);
    cmd_header_i = 64'hD0; cmd_addr_i = 40'h00_8000_0040; cmd_size_i = 3'd3; cmd_wr_i = 1'b0;
    cmd_v_i = 1'b1;
    #1;
    chk("full_ready", 64'(cmd_ready_o), 64'd0);
    step();
    chk("full_ready2", 64'(cmd_ready_o), 64'd0);
    resp_yumi_i = 1'b1;
    #1;
    chk("full_no_comb_yumi", 64'(cmd_ready_o), 64'd0);
    chk("full_head_hdr", resp_header_o, 64'hC0);
    chk("full_head_data", resp_data_o, 64'hA5A5_0000_4000_0000);
    step();
    resp_yumi_i = 1'b0;
    #1;
    chk("ready_after_pop", 64'(cmd_ready_o), 64'd1);
    b1 = npkt[1];
    step();
    cmd_v_i = 1'b0;
    chk("fifth_issued", 64'(npkt[1] - b1), 64'd1);
    exp_hdr  = '{64'hC1, 64'hC2, 64'hC3, 64'hD0};
    exp_data = '{64'hA5A5_0000_4000_0040, 64'hA5A5_0000_4000_0080,
                 64'hA5A5_0000_4000_00C0, 64'hA5A5_0000_4000_0000};
    for (int k = 0; k < 4; k++) begin
      wait_resp("drain_resp_v");
      chk("drain_hdr", resp_header_o, exp_hdr[k]);
      chk("drain_data", resp_data_o, exp_data[k]);
      pop_one();
    end

    // CSR TAGFL: data 0x41 selects bank 1, per-bank index 0x20.
    b1 = npkt[1];
    send_beat(64'hE0, 40'h00_0000_2000, 3'd3, 1'b1, 64'h41);
    chk("tagfl_opcode", 64'(lop[1][b1[10:0]]), 64'h11);
    chk("tagfl_addr", 64'(laddr[1][b1[10:0]]), 64'h800);
    chk("tagfl_data", ldata[1][b1[10:0]], 64'h41);
    wait_resp("tagfl_resp_v");
    chk("tagfl_resp_data", resp_data_o, 64'd0);
    chk("tagfl_resp_last", 64'(resp_last_o), 64'd1);
    chk("tagfl_resp_hdr", resp_header_o, 64'hE0);
    pop_one();

    // Reset in the middle of a write stream.
    for (int k = 0; k < 3; k++) send_beat(64'hE1, 40'h00_8000_0000, 3'd6, 1'b1, 64'(k));
    cmd_v_i = 1'b1;
    reset_i = 1'b0;
    #1;
    chk("midrst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("midrst_resp_v", 64'(resp_v_o), 64'd0);
    chk("midrst_init_done", 64'(init_done_o), 64'd0);
    chk("midrst_pkt_v", 64'(cache_pkt_v_o), 64'd0);
    cmd_v_i = 1'b0;
    repeat (2) step();
    b0 = npkt[0];
    reset_i = 1'b1;
    wait_init();
    chk("reclear_count", 64'(npkt[0] - b0), 64'd512);
    chk("reclear_resp_v", 64'(resp_v_o), 64'd0);
    send_beat(64'hF0, 40'h00_8000_0040, 3'd3, 1'b0, 64'd0);
    wait_resp("post_rst_resp_v");
    chk("post_rst_hdr", resp_header_o, 64'hF0);
    chk("post_rst_data", resp_data_o, 64'hA5A5_0000_4000_0000);
    pop_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
